// File: rtl/riscv_pkg.sv
// Shared RV32I load/store encodings, LSU state type and the access legality/lane helpers.
package riscv_pkg;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  // Size comes from funct3[1:0] for both loads and stores; alignment is checked on it.
  function automatic logic access_legal(input logic rd, input logic wr,
                                        input logic [2:0] f3, input logic [1:0] a);
    logic size_ok;
    logic align_ok;
    size_ok  = 1'b0;
    align_ok = 1'b1;
    if (rd && !wr)
      size_ok = (f3 == FUNCT3_LB) || (f3 == FUNCT3_LH) || (f3 == FUNCT3_LW) ||
                (f3 == FUNCT3_LBU) || (f3 == FUNCT3_LHU);
    else if (wr && !rd)
      size_ok = (f3 == FUNCT3_SB) || (f3 == FUNCT3_SH) || (f3 == FUNCT3_SW);
    case (f3[1:0])
      2'b01:   align_ok = ~a[0];
      2'b10:   align_ok = (a == 2'b00);
      default: align_ok = 1'b1;
    endcase
    return size_ok && align_ok;
  endfunction

  function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] sd);
    case (f3[1:0])
      2'b00:   return {4{sd[7:0]}};
      2'b01:   return {2{sd[15:0]}};
      default: return sd;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module lsu_load_align
  import riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata[{addr_lo, 3'b000} +: 8];
    half_v = rdata[{addr_lo[1], 4'b0000} +: 16];
    case (funct3)
      FUNCT3_LB:  load_data = {{24{byte_v[7]}}, byte_v};
      FUNCT3_LH:  load_data = {{16{half_v[15]}}, half_v};
      FUNCT3_LBU: load_data = {24'd0, byte_v};
      FUNCT3_LHU: load_data = {16'd0, half_v};
      default:    load_data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one data-memory access at a time over a req/ready bus,
// stalling the core from acceptance until the access completes or times out.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        access_fault,
  output logic        bus_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  lsu_state_t  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] data_q, data_d;
  logic        bus_err_q, bus_err_d;

  logic        access;
  logic        legal;
  logic [31:0] aligned;

  // Alignment works on the latched address/size so late input changes cannot disturb it.
  lsu_load_align u_align (
    .rdata     (dmem_rdata),
    .addr_lo   (addr_lo_q),
    .funct3    (funct3_q),
    .load_data (aligned)
  );

  always_comb begin
    access       = (mem_read | mem_write) & rst_n;
    legal        = access_legal(mem_read, mem_write, funct3, addr[1:0]);
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    addr_lo_d    = addr_lo_q;
    funct3_d     = funct3_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    data_d       = data_q;
    bus_err_d    = 1'b0;
    stall        = 1'b0;
    access_fault = 1'b0;
    case (state_q)
      IDLE: begin
        if (access && legal) begin
          stall     = 1'b1;
          state_d   = REQ;
          req_d     = 1'b1;
          cnt_d     = 8'd0;
          we_d      = mem_write;
          addr_d    = {addr[31:2], 2'b00};
          addr_lo_d = addr[1:0];
          funct3_d  = funct3;
          be_d      = lane_be(funct3, addr[1:0]);
          wdata_d   = lane_wdata(funct3, store_data);
        end else if (access) begin
          access_fault = 1'b1;
        end
      end
      REQ: begin
        stall = 1'b1;
        cnt_d = cnt_q + 8'd1;
        // Ready wins over a timeout landing on the same cycle.
        if (dmem_ready) begin
          data_d  = aligned;
          state_d = DONE;
          req_d   = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          data_d    = 32'd0;
          bus_err_d = 1'b1;
          state_d   = DONE;
          req_d     = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      addr_lo_q <= 2'd0;
      funct3_q  <= 3'd0;
      be_q      <= 4'd0;
      wdata_q   <= 32'd0;
      data_q    <= 32'd0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      addr_lo_q <= addr_lo_d;
      funct3_q  <= funct3_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      data_q    <= data_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign load_data  = data_q;
  assign bus_err    = bus_err_q;
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit against a plain-arithmetic access model.
module tb_load_store_unit;
  import riscv_pkg::*;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0, store_data = 32'd0;
  logic        stall, access_fault, bus_err;
  logic [31:0] load_data;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready = 1'b0;
  logic [31:0] dmem_rdata = 32'd0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .store_data(store_data), .stall(stall),
    .load_data(load_data), .access_fault(access_fault), .bus_err(bus_err),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata)
  );

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit m_legal(input bit rd, input bit wr, input logic [2:0] f3,
                                 input logic [31:0] a);
    int f = int'(f3);
    if (rd && wr) return 0;
    if (rd && !(f == 0 || f == 1 || f == 2 || f == 4 || f == 5)) return 0;
    if (wr && f > 2) return 0;
    return (int'(a[1:0]) % nbytes(f3)) == 0;
  endfunction

  function automatic int m_offset(input logic [2:0] f3, input logic [31:0] a);
    int lo = int'(a[1:0]);
    return lo - (lo % nbytes(f3));
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int v = ((1 << nbytes(f3)) - 1) << m_offset(f3, a);
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
    longint chunk, w;
    int nb = nbytes(f3);
    chunk = longint'(sd) & ((64'd1 << (8 * nb)) - 1);
    w = 0;
    for (int k = 0; k < 4 / nb; k++) w = w | (chunk << (8 * nb * k));
    return w[31:0];
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] rd);
    longint v;
    int bits = 8 * nbytes(f3);
    v = (longint'(rd) >> (8 * m_offset(f3, a))) & ((64'd1 << bits) - 1);
    if (f3[2] == 1'b0 && bits < 32 && v >= (64'd1 << (bits - 1))) v = v - (64'd1 << bits);
    return v[31:0];
  endfunction

  // One complete access: IDLE cycle, wt wait cycles in REQ (ready on REQ cycle wt), DONE.
  task automatic do_access(input bit rd, input bit wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] sd,
                           input logic [31:0] rdv, input int wt, input bit preload,
                           input string nm, output int stalls);
    bit legal;
    bit tmo;
    int reqc;
    logic [31:0] exp_ld;
    legal = m_legal(rd, wr, f3, a);
    tmo = (wt >= T);
    reqc = tmo ? T : wt + 1;
    exp_ld = tmo ? 32'd0 : m_load(f3, a, rdv);
    stalls = 0;
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = sd; dmem_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (stall !== legal) begin n_err++; $display("FAIL %s idle_stall got=%b want=%b", nm, stall, legal); end
    n_cmp++;
    if (access_fault !== !legal) begin n_err++; $display("FAIL %s fault got=%b want=%b", nm, access_fault, !legal); end
    n_cmp++;
    if (dmem_req !== 1'b0 || bus_err !== 1'b0) begin n_err++; $display("FAIL %s idle_req/bus_err got=%b/%b want=0/0", nm, dmem_req, bus_err); end
    if (stall === 1'b1) stalls++;
    if (!legal) begin
      @(posedge clk); #1; mem_read = 1'b0; mem_write = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (dmem_req !== 1'b0 || stall !== 1'b0) begin n_err++; $display("FAIL %s post_fault req/stall got=%b/%b want=0/0", nm, dmem_req, stall); end
      return;
    end
    for (int c = 0; c < reqc; c++) begin
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0;
      addr = $urandom; store_data = $urandom; funct3 = 3'($urandom);
      dmem_ready = (c == wt);
      dmem_rdata = (c == wt) ? rdv : $urandom;
      @(negedge clk);
      if (stall === 1'b1) stalls++;
      n_cmp++;
      if (dmem_req !== 1'b1 || stall !== 1'b1) begin n_err++; $display("FAIL %s req_cyc%0d req/stall got=%b/%b want=1/1", nm, c, dmem_req, stall); end
      n_cmp++;
      if (dmem_we !== wr || dmem_addr !== {a[31:2], 2'b00} || dmem_be !== m_be(f3, a)) begin
        n_err++;
        $display("FAIL %s bus we/addr/be got=%b/%h/%b want=%b/%h/%b", nm, dmem_we, dmem_addr, dmem_be, wr, {a[31:2], 2'b00}, m_be(f3, a));
      end
      if (wr) begin
        n_cmp++;
        if (dmem_wdata !== m_wdata(f3, sd)) begin n_err++; $display("FAIL %s wdata got=%h want=%h", nm, dmem_wdata, m_wdata(f3, sd)); end
      end
    end
    @(posedge clk); #1;
    dmem_ready = 1'($urandom); dmem_rdata = $urandom;
    if (preload) begin
      mem_read = 1'b1; funct3 = FUNCT3_LW; addr = $urandom & 32'hFFFF_FFFC;
    end
    @(negedge clk);
    if (stall === 1'b1) stalls++;
    n_cmp++;
    if (stall !== 1'b0 || dmem_req !== 1'b0) begin n_err++; $display("FAIL %s done req/stall got=%b/%b want=0/0", nm, dmem_req, stall); end
    n_cmp++;
    if (bus_err !== tmo) begin n_err++; $display("FAIL %s bus_err got=%b want=%b", nm, bus_err, tmo); end
    if (rd || tmo) begin
      n_cmp++;
      if (load_data !== exp_ld) begin n_err++; $display("FAIL %s load_data got=%h want=%h", nm, load_data, exp_ld); end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if ({stall, access_fault, bus_err, dmem_req, dmem_we} !== 5'b0 || load_data !== 32'd0 ||
        dmem_addr !== 32'd0 || dmem_be !== 4'd0 || dmem_wdata !== 32'd0) begin
      n_err++;
      $display("FAIL reset outputs stall=%b req=%b ld=%h addr=%h be=%b wd=%h want all 0", stall, dmem_req, load_data, dmem_addr, dmem_be, dmem_wdata);
    end
    @(posedge clk); #1; rst_n = 1'b1;
  endtask

  task automatic test_directed();
    int s;
    do_access(0, 1, FUNCT3_SW, 32'h104, 32'hDEADBEEF, 32'h0, 0, 0, "sw_104", s);
    n_cmp++;
    if (s !== 2) begin n_err++; $display("FAIL sw_104 stall_cycles got=%0d want=2", s); end
    do_access(1, 0, FUNCT3_LB,  32'h103, 32'h0, 32'h80AA55CC, 1, 0, "lb_103", s);
    do_access(1, 0, FUNCT3_LBU, 32'h103, 32'h0, 32'h80AA55CC, 0, 0, "lbu_103", s);
    do_access(0, 1, FUNCT3_SH,  32'h102, 32'h0000BEEF, 32'h0, 2, 0, "sh_102", s);
    do_access(1, 0, FUNCT3_LW,  32'h102, 32'h0, 32'h0, 0, 0, "lw_misaligned", s);
    do_access(1, 1, FUNCT3_LW,  32'h100, 32'h0, 32'h0, 0, 0, "rd_and_wr", s);
    do_access(0, 1, FUNCT3_LBU, 32'h100, 32'h0, 32'h0, 0, 0, "store_bad_f3", s);
  endtask

  task automatic test_timeout();
    int s;
    do_access(1, 0, FUNCT3_LW, 32'h200, 32'h0, 32'h12345678, 1000, 0, "timeout", s);
    n_cmp++;
    if (s !== T + 1) begin n_err++; $display("FAIL timeout stall_cycles got=%0d want=%0d", s, T + 1); end
    do_access(1, 0, FUNCT3_LH, 32'h202, 32'h0, 32'h8001_7FFF, T - 1, 0, "ready_at_last", s);
  endtask

  task automatic test_reset_in_req();
    int s;
    @(posedge clk); #1;
    mem_write = 1'b1; funct3 = FUNCT3_SW; addr = 32'h300; store_data = 32'hCAFEF00D;
    @(posedge clk); #1;
    mem_write = 1'b0; dmem_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (dmem_req !== 1'b1) begin n_err++; $display("FAIL rst_req pre got=%b want=1", dmem_req); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (dmem_req !== 1'b0 || stall !== 1'b0) begin n_err++; $display("FAIL rst_req async req/stall got=%b/%b want=0/0", dmem_req, stall); end
    @(posedge clk); #1; rst_n = 1'b1;
    do_access(0, 1, FUNCT3_SW, 32'h304, 32'h11223344, 32'h0, 1, 0, "sw_after_rst", s);
  endtask

  task automatic test_back_to_back();
    int s;
    do_access(1, 0, FUNCT3_LW, 32'h400, 32'h0, 32'hA5A5_0001, 0, 1, "b2b_first", s);
    do_access(1, 0, FUNCT3_LW, 32'h404, 32'h0, 32'h5A5A_0002, 0, 0, "b2b_second", s);
  endtask

  task automatic test_random();
    int s;
    bit rd, wr;
    int sel;
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 9);
      rd = (sel < 5) || (sel == 9);
      wr = (sel >= 5);
      do_access(rd, wr, 3'($urandom), $urandom, $urandom, $urandom,
                $urandom_range(0, T + 1), 1'($urandom), $sformatf("rand%0d", i), s);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_reset_in_req();
    test_back_to_back();
    test_random();
    @(posedge clk); #1; mem_read = 1'b0; mem_write = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
